// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU front end.
// Contents: instruction field constants (opcode, funct3, funct7), ALU control
// codes, the sequencer state type, the decoded instruction class and a
// classify() helper that maps opcode/funct3/funct7 to that class.
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_ADD = 7'b0000000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_BNE = 4'b1111;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    CL_ADD  = 2'd0,
    CL_ADDI = 2'd1,
    CL_BNE  = 2'd2,
    CL_ILL  = 2'd3
  } insn_class_t;

  // Only the fields that take part in classification are passed in.
  function automatic insn_class_t classify(input logic [6:0] opcode,
                                           input logic [2:0] funct3,
                                           input logic [6:0] funct7);
    insn_class_t cl;
    cl = CL_ILL;
    if (opcode == OP_R && funct3 == F3_ADD && funct7 == F7_ADD) cl = CL_ADD;
    else if (opcode == OP_IMM && funct3 == F3_ADD)              cl = CL_ADDI;
    else if (opcode == OP_BRANCH && funct3 == F3_BNE)           cl = CL_BNE;
    return cl;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file.
// Ports:
//   clk, rst              clock, synchronous active-high reset (all regs -> 0)
//   raddr1_i/rdata1_o     asynchronous read port 1
//   raddr2_i/rdata2_o     asynchronous read port 2
//   we_i/waddr_i/wdata_i  synchronous write port (writes to x0 are dropped)
//   a0_o                  live copy of x10
module reg_file #(
  parameter int DATA_W = 8,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic [AW-1:0]     raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] a0_o
);

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // x0 is forced to zero on read, so its storage never matters.
  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
  assign a0_o     = regs_q[10];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control/operand front end of the 8-bit CPU (ALU initiator).
// Every instruction walks FETCH -> DECODE -> EXECUTE -> WRITEBACK.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   run          high lets the sequencer leave FETCH
//   instr_addr   registered PC to the synchronous instruction memory
//   instr        instruction word, valid the cycle after instr_addr changes
//   alu_op1/2    registered ALU operands, alu_ctrl = add (0000) / bne (1111)
//   sum, eq      ALU result and "operands differ" flag, sampled in EXECUTE
//   a0           live copy of x10
//   retire       high for the single WRITEBACK cycle of each instruction
//   illegal      sticky undecodable-instruction flag
//   dbg_state    current sequencer state
// Handshake: there is no valid/ready; the ALU is purely combinational and the
// operands are stable for the whole EXECUTE cycle, so sum/eq are sampled on
// the edge that ends EXECUTE.
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [PC_W-1:0]   instr_addr,
  input  logic [31:0]       instr,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] sum,
  input  logic              eq,
  output logic [DATA_W-1:0] a0,
  output logic              retire,
  output logic              illegal,
  output seq_state_t        dbg_state
);

  localparam int AW = $clog2(NREG);

  seq_state_t        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  insn_class_t       cls_q, cls_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [PC_W-1:0]   bimm_q, bimm_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              eq_q, eq_d;
  logic              ill_q, ill_d;

  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic              rf_we;
  insn_class_t       dec_cls;
  logic [12:0]       dec_bimm;

  // Operands are read straight from the incoming word during DECODE and
  // registered, so the ALU sees them for the whole EXECUTE cycle.
  reg_file #(.DATA_W(DATA_W), .NREG(NREG), .AW(AW)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (AW'(instr[19:15])),
    .rdata1_o (rs1_data),
    .raddr2_i (AW'(instr[24:20])),
    .rdata2_o (rs2_data),
    .we_i     (rf_we),
    .waddr_i  (rd_q),
    .wdata_i  (sum_q),
    .a0_o     (a0)
  );

  assign dec_cls  = classify(instr[6:0], instr[14:12], instr[31:25]);
  assign dec_bimm = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cls_d   = cls_q;
    rd_d    = rd_q;
    bimm_d  = bimm_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    ctrl_d  = ctrl_q;
    sum_d   = sum_q;
    eq_d    = eq_q;
    ill_d   = ill_q;
    rf_we   = 1'b0;
    case (state_q)
      FETCH: begin
        if (run) state_d = DECODE;
      end
      DECODE: begin
        cls_d   = dec_cls;
        rd_d    = AW'(instr[11:7]);
        bimm_d  = PC_W'($signed(dec_bimm));
        state_d = EXECUTE;
        // Illegal words leave the ALU operands untouched.
        if (dec_cls != CL_ILL) begin
          op1_d  = rs1_data;
          op2_d  = (dec_cls == CL_ADDI) ? DATA_W'($signed(instr[31:20])) : rs2_data;
          ctrl_d = (dec_cls == CL_BNE) ? ALU_BNE : ALU_ADD;
        end
      end
      EXECUTE: begin
        sum_d   = sum;
        eq_d    = eq;
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        state_d = FETCH;
        pc_d    = pc_q + PC_W'(4);
        case (cls_q)
          CL_ADD, CL_ADDI: rf_we = 1'b1;
          CL_BNE:          if (eq_q) pc_d = pc_q + bimm_q;
          default:         ill_d = 1'b1;
        endcase
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= '0;
      cls_q   <= CL_ILL;
      rd_q    <= '0;
      bimm_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      ctrl_q  <= ALU_ADD;
      sum_q   <= '0;
      eq_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cls_q   <= cls_d;
      rd_q    <= rd_d;
      bimm_q  <= bimm_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      ctrl_q  <= ctrl_d;
      sum_q   <= sum_d;
      eq_q    <= eq_d;
      ill_q   <= ill_d;
    end
  end

  assign instr_addr = pc_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_ctrl   = ctrl_q;
  assign retire     = (state_q == WRITEBACK);
  assign illegal    = ill_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  import cpu_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst, run;
  logic [7:0] instr_addr, alu_op1, alu_op2, sum, a0;
  logic [31:0] instr;
  logic [3:0] alu_ctrl;
  logic       eq, retire, illegal;
  seq_state_t dbg_state;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .instr_addr(instr_addr), .instr(instr),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl), .sum(sum), .eq(eq),
    .a0(a0), .retire(retire), .illegal(illegal), .dbg_state(dbg_state)
  );

  // Synchronous instruction memory and a combinational ALU stand-in.
  logic [31:0] imem [64];
  always @(posedge clk) instr <= imem[instr_addr[7:2]];
  assign sum = alu_op1 + alu_op2;
  assign eq  = (alu_op1 != alu_op2);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_state(input seq_state_t s, input string tag);
    int n = 0;
    while (dbg_state !== s && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (dbg_state !== s) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout_%s: state %0d expected %0d", tag, dbg_state, s);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
    logic [11:0] i;
    i = 12'(imm);
    return {i, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
    return {7'b0000000, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_bne(input int rs1, input int rs2, input int off);
    logic [12:0] b;
    b = 13'(off);
    return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'b001, b[4:1], b[11], 7'b1100011};
  endfunction

  // ---------------- reference model (ISA level) ----------------
  logic [7:0] m_r [32];
  logic [7:0] m_pc;
  bit         m_ill;

  typedef enum {K_ADD, K_ADDI, K_BNE, K_ILL} kind_t;

  function automatic kind_t model_kind(input logic [31:0] w);
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'd0) return K_ADD;
    if (w[6:0] == 7'h13 && w[14:12] == 3'd0) return K_ADDI;
    if (w[6:0] == 7'h63 && w[14:12] == 3'd1) return K_BNE;
    return K_ILL;
  endfunction

  function automatic logic [31:0] rnd_instr();
    int regs [5] = '{0, 1, 2, 3, 10};
    int k = int'($urandom_range(0, 15));
    int rd  = regs[$urandom_range(0, 4)];
    int rs1 = regs[$urandom_range(0, 4)];
    int rs2 = regs[$urandom_range(0, 4)];
    if (k < 4)   return enc_add(rd, rs1, rs2);
    if (k < 10)  return enc_addi(rd, rs1, int'($urandom_range(0, 4095)) - 2048);
    if (k < 13)  return enc_bne(rs1, rs2, 4 * int'($urandom_range(0, 16)) - 32);
    if (k == 13) return enc_add(rd, rs1, rs2) | 32'h4000_0000;  // sub: not supported
    if (k == 14) return enc_bne(rs1, rs2, 8) ^ 32'h0000_3000;   // funct3 010: not bne
    return $urandom();
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] w;
    bit          chk_ops;
    logic [7:0]  op1, op2;
    logic [3:0]  ctrl;
    logic [7:0]  exp_a0, exp_pc;
    bit          exp_ill;
  } vec_t;

  vec_t tbl [$];

  initial begin
    int prev_wb;
    int hold_bad;

    // Execution trace: each row is one instruction in executed order.
    tbl.push_back('{8'h00, enc_addi(10, 0, 5),    1, 8'h00, 8'h05, 4'h0, 8'h05, 8'h04, 0});
    tbl.push_back('{8'h04, enc_addi(10, 0, -1),   1, 8'h00, 8'hFF, 4'h0, 8'hFF, 8'h08, 0});
    tbl.push_back('{8'h08, enc_addi(10, 10, 1),   1, 8'hFF, 8'h01, 4'h0, 8'h00, 8'h0C, 0});
    tbl.push_back('{8'h0C, enc_addi(0, 0, 7),     1, 8'h00, 8'h07, 4'h0, 8'h00, 8'h10, 0});
    tbl.push_back('{8'h10, enc_add(10, 0, 0),     1, 8'h00, 8'h00, 4'h0, 8'h00, 8'h14, 0});
    tbl.push_back('{8'h14, enc_addi(1, 0, 3),     1, 8'h00, 8'h03, 4'h0, 8'h00, 8'h18, 0});
    tbl.push_back('{8'h18, enc_addi(10, 10, 1),   1, 8'h00, 8'h01, 4'h0, 8'h01, 8'h1C, 0});
    tbl.push_back('{8'h1C, enc_addi(1, 1, -1),    1, 8'h03, 8'hFF, 4'h0, 8'h01, 8'h20, 0});
    tbl.push_back('{8'h20, enc_bne(1, 0, -8),     1, 8'h02, 8'h00, 4'hF, 8'h01, 8'h18, 0});
    tbl.push_back('{8'h18, enc_addi(10, 10, 1),   1, 8'h01, 8'h01, 4'h0, 8'h02, 8'h1C, 0});
    tbl.push_back('{8'h1C, enc_addi(1, 1, -1),    1, 8'h02, 8'hFF, 4'h0, 8'h02, 8'h20, 0});
    tbl.push_back('{8'h20, enc_bne(1, 0, -8),     1, 8'h01, 8'h00, 4'hF, 8'h02, 8'h18, 0});
    tbl.push_back('{8'h18, enc_addi(10, 10, 1),   1, 8'h02, 8'h01, 4'h0, 8'h03, 8'h1C, 0});
    tbl.push_back('{8'h1C, enc_addi(1, 1, -1),    1, 8'h01, 8'hFF, 4'h0, 8'h03, 8'h20, 0});
    tbl.push_back('{8'h20, enc_bne(1, 0, -8),     1, 8'h00, 8'h00, 4'hF, 8'h03, 8'h24, 0});
    tbl.push_back('{8'h24, 32'hFFFF_FFFF,         0, 8'h00, 8'h00, 4'h0, 8'h03, 8'h28, 1});
    tbl.push_back('{8'h28, enc_addi(10, 10, 1),   1, 8'h03, 8'h01, 4'h0, 8'h04, 8'h2C, 1});
    tbl.push_back('{8'h2C, enc_bne(10, 0, 208),   1, 8'h04, 8'h00, 4'hF, 8'h04, 8'hFC, 1});
    tbl.push_back('{8'hFC, enc_addi(10, 10, 1),   1, 8'h04, 8'h01, 4'h0, 8'h05, 8'h00, 1});

    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    foreach (tbl[i]) imem[tbl[i].addr[7:2]] = tbl[i].w;

    // ---- reset state, with run low ----
    run = 1'b0;
    rst = 1'b0;
    do_reset();
    check("rst_state",      dbg_state, FETCH);
    check("rst_instr_addr", instr_addr, 8'h00);
    check("rst_a0",         a0, 8'h00);
    check("rst_op1",        alu_op1, 8'h00);
    check("rst_op2",        alu_op2, 8'h00);
    check("rst_ctrl",       alu_ctrl, 4'h0);
    check("rst_retire",     retire, 1'b0);
    check("rst_illegal",    illegal, 1'b0);
    rst = 1'b0;

    // ---- run low holds in FETCH ----
    hold_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (instr_addr !== 8'h00 || retire !== 1'b0 || dbg_state !== FETCH) hold_bad++;
    end
    check("run0_hold", hold_bad, 0);
    run = 1'b1;
    @(negedge clk);
    check("run1_start_decode", dbg_state, DECODE);

    // ---- table-driven trace ----
    prev_wb = 0;
    foreach (tbl[i]) begin
      wait_state(EXECUTE, "tbl_ex");
      if (tbl[i].chk_ops) begin
        check($sformatf("tbl%0d_op1", i),  alu_op1, tbl[i].op1);
        check($sformatf("tbl%0d_op2", i),  alu_op2, tbl[i].op2);
        check($sformatf("tbl%0d_ctrl", i), alu_ctrl, tbl[i].ctrl);
      end
      wait_state(WRITEBACK, "tbl_wb");
      check($sformatf("tbl%0d_retire", i), retire, 1'b1);
      if (i > 0) check($sformatf("tbl%0d_cycles", i), cyc - prev_wb, 4);
      prev_wb = cyc;
      @(negedge clk);
      check($sformatf("tbl%0d_retire_drop", i), retire, 1'b0);
      check($sformatf("tbl%0d_a0", i),          a0, tbl[i].exp_a0);
      check($sformatf("tbl%0d_pc", i),          instr_addr, tbl[i].exp_pc);
      check($sformatf("tbl%0d_illegal", i),     illegal, tbl[i].exp_ill);
    end

    // ---- reset in the middle of EXECUTE ----
    run = 1'b0;
    do_reset();
    rst = 1'b0;
    imem[0] = enc_addi(10, 0, 9);
    imem[1] = enc_addi(10, 0, 9);
    run = 1'b1;
    wait_state(EXECUTE, "rst_ex");
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state",  dbg_state, FETCH);
    check("midrst_a0",     a0, 8'h00);
    check("midrst_pc",     instr_addr, 8'h00);
    check("midrst_retire", retire, 1'b0);
    rst = 1'b0;

    // ---- run dropped after FETCH: instruction still completes ----
    wait_state(DECODE, "runlow_dec");
    run = 1'b0;
    wait_state(WRITEBACK, "runlow_wb");
    check("runlow_retire", retire, 1'b1);
    @(negedge clk);
    check("runlow_a0", a0, 8'h09);
    check("runlow_pc", instr_addr, 8'h04);
    hold_bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (dbg_state !== FETCH || retire !== 1'b0) hold_bad++;
    end
    check("runlow_hold", hold_bad, 0);

    // ---- randomized program against the ISA-level model ----
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = rnd_instr();
    for (int i = 0; i < 32; i++) m_r[i] = 8'h00;
    m_pc  = 8'h00;
    m_ill = 1'b0;
    run   = 1'b1;
    for (int n = 0; n < 120; n++) begin
      logic [31:0] w;
      kind_t       k;
      logic [7:0]  v1, v2;
      int          off;
      w  = imem[m_pc[7:2]];
      k  = model_kind(w);
      v1 = m_r[w[19:15]];
      v2 = (k == K_ADDI) ? w[27:20] : m_r[w[24:20]];
      wait_state(EXECUTE, "rnd_ex");
      if (k != K_ILL) begin
        check("rnd_op1",  alu_op1, v1);
        check("rnd_op2",  alu_op2, v2);
        check("rnd_ctrl", alu_ctrl, (k == K_BNE) ? 4'hF : 4'h0);
      end
      wait_state(WRITEBACK, "rnd_wb");
      check("rnd_retire", retire, 1'b1);
      case (k)
        K_ADD, K_ADDI: begin
          if (w[11:7] != 5'd0) m_r[w[11:7]] = v1 + v2;
          m_pc = m_pc + 8'd4;
        end
        K_BNE: begin
          off = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
          if (v1 != v2) m_pc = m_pc + 8'(off);
          else          m_pc = m_pc + 8'd4;
        end
        default: begin
          m_ill = 1'b1;
          m_pc  = m_pc + 8'd4;
        end
      endcase
      @(negedge clk);
      check("rnd_a0",      a0, m_r[10]);
      check("rnd_pc",      instr_addr, m_pc);
      check("rnd_illegal", illegal, m_ill);
      if ($urandom_range(0, 3) == 0) begin
        run = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        check("rnd_hold_state", dbg_state, FETCH);
        check("rnd_hold_pc",    instr_addr, m_pc);
        run = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control/operand front end for the bare-bones 8-bit CPU; the initiator side of the ALU interface.
- Fetches 32-bit RV32I-subset instructions (add, addi, bne) from a synchronous instruction memory and decodes them.
- Reads operands from an internal register file and drives alu_op1/alu_op2/alu_ctrl.
- Captures sum/eq, writes back results, updates the PC, and exposes register a0 (x10) for display.

Parameters:
- DATA_W, 8, register and ALU operand width.
- PC_W, 8, program counter / instruction address width.
- NREG, 32, number of architectural registers (x0 hardwired to zero).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  high permits leaving FETCH; low holds the sequencer in FETCH.
- instr_addr  out  PC_W  registered PC to instruction memory.
- instr  in  32  instruction word, valid the cycle after instr_addr changes.
- alu_op1  out  DATA_W  rs1 value.
- alu_op2  out  DATA_W  rs2 value or immediate.
- alu_ctrl  out  4  4'b0000 add, 4'b1111 bne compare.
- sum  in  DATA_W  ALU result.
- eq  in  1  ALU flag, high = operands differ (bne taken).
- a0  out  DATA_W  live copy of x10.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  sticky, set on an undecodable instruction.

Behaviour:
- Reset (rst high at an edge, any state): state=FETCH, pc=0, instr_addr=0, all registers=0, a0=0, alu_op1=alu_op2=0, alu_ctrl=4'b0000, retire=0, illegal=0. Reset overrides any in-flight instruction: no writeback, no PC update.
- FSM: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH. Each instruction takes exactly 4 cycles.
- FETCH: instr_addr=pc. Advance to DECODE only if run=1.
- DECODE: latch instr. Read rs1=instr[19:15] and rs2=instr[24:20]. Classify:
  - add: opcode 0110011, funct3 000, funct7 0000000.
  - addi: opcode 0010011, funct3 000.
  - bne: opcode 1100011, funct3 001.
  - Anything else is illegal.
- EXECUTE: drive alu_op1=R[rs1].
  - add: alu_op2=R[rs2], alu_ctrl=0000.
  - addi: alu_op2=imm[11:0] sign-extended, truncated to DATA_W; alu_ctrl=0000.
  - bne: alu_op2=R[rs2], alu_ctrl=1111.
  - Sample sum/eq at the end of EXECUTE. Operands are registered, so the ALU sees them for the whole cycle.
- WRITEBACK:
  - add/addi: R[rd]=sum if rd!=0; writes to x0 are discarded.
  - bne with sampled eq=1: pc = pc + B-immediate (sign-extended, LSB 0), modulo 2^PC_W.
  - All other cases, including bne not taken: pc = pc+4, modulo 2^PC_W.
  - retire=1 for this cycle only.
  - Illegal instruction: no register write, pc+4, illegal<=1, retire=1.
- Arithmetic: the ALU sum wraps modulo 2^DATA_W. PC arithmetic wraps modulo 2^PC_W; 0xFC+4 -> 0x00.
- a0 reflects a writeback to x10 from the cycle after WRITEBACK onward.
- alu_op1, alu_op2 and alu_ctrl hold their last values outside EXECUTE.
- run low: the sequencer holds in FETCH only; an instruction already past FETCH completes.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_R=7'b0110011, OP_IMM=7'b0010011, OP_BRANCH=7'b1100011.
  - funct3 constants F3_ADD=3'b000, F3_BNE=3'b001.
  - ALU control constants ALU_ADD=4'b0000, ALU_BNE=4'b1111.
  - state enum seq_state_t {FETCH, DECODE, EXECUTE, WRITEBACK}.
- One sub-module, reg_file: 2 asynchronous read ports, 1 synchronous write port, x0 hardwired zero, a0 tap output, synchronous reset to zero.

Test Plan:
- Reset, then addi x10,x0,5 at addr 0 -> alu_op1=0, alu_op2=5, alu_ctrl=0000 in EXECUTE; a0=5 and instr_addr=4 after 4 cycles; one retire pulse.
- addi x10,x0,-1 then addi x10,x10,1 -> a0=0xFF, then a0=0x00 (wrap).
- addi x1,x0,3; bne x1,x0,-8 loop with decrementing addi x1,x1,-1:
  - bne taken (eq=1) -> pc jumps back by 8.
  - Final bne with eq=0 -> pc+4.
- addi x0,x0,7 -> x0 reads 0 afterwards; instruction 0xFFFFFFFF -> illegal=1 (stays set), no register change, pc+4.
- run=0 from reset -> instr_addr stays 0 and retire never pulses; run=1 -> execution starts next cycle.
- rst asserted during EXECUTE of addi x10,x0,9 -> a0 stays 0, pc=0, state FETCH on the next cycle.
